// File: rtl/iir_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : iir_frame_ctrl
// Brief    : Frame sequencer for the SOS IIR cascade with backpressure and watchdog.
// Revision : 1.0 - initial parametrised release
// ============================================================================
module iir_frame_ctrl #(
  parameter int DW      = 24,
  parameter int AW      = 11,
  parameter int TMO_W   = 16,
  parameter int TIMEOUT = 4096
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 cont_mode,
  input  logic [AW:0]          frame_len,
  input  logic                 data_in_valid,
  output logic                 data_in_ready,
  input  logic                 sos_out_valid,
  input  logic signed [DW-1:0] sos_out_data,
  output logic                 pipeline_en,
  output logic [AW-1:0]        addr,
  output logic signed [DW-1:0] data_out,
  output logic                 data_out_valid,
  input  logic                 data_out_ready,
  output logic                 busy,
  output logic                 stable_out,
  output logic                 filter_done,
  output logic                 timeout_err,
  output logic [15:0]          frame_cnt
);

  localparam logic [AW:0]    c_max_len  = {1'b1, {AW{1'b0}}};
  localparam logic [TMO_W-1:0] c_tmo_last = TMO_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_DRAIN = 3'd2,
    S_DONE  = 3'd3,
    S_ERR   = 3'd4
  } state_t;

  state_t               r_state;
  logic [AW:0]          r_len;
  logic                 r_cont;
  logic [AW:0]          r_in_cnt;
  logic [AW:0]          r_out_cnt;
  logic [TMO_W-1:0]     r_wdog;
  logic signed [DW-1:0] r_dout;
  logic [AW-1:0]        r_addr;
  logic                 r_dout_valid;
  logic                 r_stable;
  logic                 r_filter_done;
  logic                 r_timeout_err;
  logic [15:0]          r_frame_cnt;

  logic        w_run;
  logic        w_stall;
  logic        w_pipe_en;
  logic        w_acc;
  logic        w_in_fire;
  logic [AW:0] w_len_dec;
  logic [AW:0] w_out_next;

  // Stall is combinational so the cascade freezes in the very cycle the sink blocks.
  assign w_run      = (r_state == S_RUN);
  assign w_stall    = r_dout_valid & ~data_out_ready;
  assign w_pipe_en  = w_run & ~w_stall;
  assign w_acc      = sos_out_valid & w_pipe_en & (r_out_cnt < r_len);
  assign w_in_fire  = data_in_valid & data_in_ready;
  assign w_out_next = r_out_cnt + 1'b1;
  assign w_len_dec  = ((frame_len == '0) || (frame_len > c_max_len)) ? c_max_len : frame_len;

  assign data_in_ready  = w_run & (r_in_cnt < r_len) & w_pipe_en;
  assign pipeline_en    = w_pipe_en;
  assign addr           = r_addr;
  assign data_out       = r_dout;
  assign data_out_valid = r_dout_valid;
  assign busy           = (r_state != S_IDLE);
  assign stable_out     = r_stable;
  assign filter_done    = r_filter_done;
  assign timeout_err    = r_timeout_err;
  assign frame_cnt      = r_frame_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_len         <= '0;
      r_cont        <= 1'b0;
      r_in_cnt      <= '0;
      r_out_cnt     <= '0;
      r_wdog        <= '0;
      r_dout        <= '0;
      r_addr        <= '0;
      r_dout_valid  <= 1'b0;
      r_stable      <= 1'b0;
      r_filter_done <= 1'b0;
      r_timeout_err <= 1'b0;
      r_frame_cnt   <= '0;
    end else begin
      r_filter_done <= 1'b0;
      if (abort) begin
        r_state      <= S_IDLE;
        r_dout_valid <= 1'b0;
        r_in_cnt     <= '0;
        r_out_cnt    <= '0;
        r_wdog       <= '0;
        r_stable     <= 1'b0;
      end else begin
        if (w_acc) begin
          r_dout       <= sos_out_data;
          r_addr       <= r_out_cnt[AW-1:0];
          r_dout_valid <= 1'b1;
          r_out_cnt    <= w_out_next;
          r_stable     <= 1'b1;
        end else if (data_out_ready) begin
          r_dout_valid <= 1'b0;
        end

        if (w_in_fire) begin
          r_in_cnt <= r_in_cnt + 1'b1;
        end

        case (r_state)
          S_IDLE, S_ERR: begin
            if (start) begin
              r_state       <= S_RUN;
              r_len         <= w_len_dec;
              r_cont        <= cont_mode;
              r_in_cnt      <= '0;
              r_out_cnt     <= '0;
              r_wdog        <= '0;
              r_frame_cnt   <= '0;
              r_timeout_err <= 1'b0;
            end
          end
          S_RUN: begin
            if (w_acc) begin
              r_wdog <= '0;
              if (w_out_next == r_len) begin
                r_state <= S_DRAIN;
              end
            end else if (r_wdog == c_tmo_last) begin
              r_state       <= S_ERR;
              r_timeout_err <= 1'b1;
            end else begin
              r_wdog <= r_wdog + 1'b1;
            end
          end
          S_DRAIN: begin
            if (!r_dout_valid || data_out_ready) begin
              r_state <= S_DONE;
            end
          end
          S_DONE: begin
            r_filter_done <= 1'b1;
            r_frame_cnt   <= r_frame_cnt + 1'b1;
            r_in_cnt      <= '0;
            r_out_cnt     <= '0;
            r_wdog        <= '0;
            if (r_cont) begin
              r_state <= S_RUN;
            end else begin
              r_state  <= S_IDLE;
              r_stable <= 1'b0;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_iir_frame_ctrl.sv
`default_nettype none
// Bench for iir_frame_ctrl: randomized handshakes checked against a transaction scoreboard.
module tb_iir_frame_ctrl;
  localparam int DW = 24;
  localparam int AW = 11;
  localparam int MAXLEN = 2048;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 start = 1'b0;
  logic                 abort = 1'b0;
  logic                 cont_mode = 1'b0;
  logic [AW:0]          frame_len = '0;
  logic                 data_in_valid = 1'b0;
  logic                 sos_out_valid = 1'b0;
  logic signed [DW-1:0] sos_out_data = '0;
  logic                 data_out_ready = 1'b0;

  logic                 data_in_ready, pipeline_en, data_out_valid;
  logic                 busy, stable_out, filter_done, timeout_err;
  logic [AW-1:0]        addr;
  logic signed [DW-1:0] data_out;
  logic [15:0]          frame_cnt;

  logic                 wd_data_in_ready, wd_pipeline_en, wd_data_out_valid;
  logic                 wd_busy, wd_stable_out, wd_filter_done, wd_timeout_err;
  logic [AW-1:0]        wd_addr;
  logic signed [DW-1:0] wd_data_out;
  logic [15:0]          wd_frame_cnt;

  iir_frame_ctrl #(.DW(DW), .AW(AW), .TMO_W(16), .TIMEOUT(4096)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .cont_mode(cont_mode),
    .frame_len(frame_len), .data_in_valid(data_in_valid), .data_in_ready(data_in_ready),
    .sos_out_valid(sos_out_valid), .sos_out_data(sos_out_data), .pipeline_en(pipeline_en),
    .addr(addr), .data_out(data_out), .data_out_valid(data_out_valid),
    .data_out_ready(data_out_ready), .busy(busy), .stable_out(stable_out),
    .filter_done(filter_done), .timeout_err(timeout_err), .frame_cnt(frame_cnt)
  );

  iir_frame_ctrl #(.DW(DW), .AW(AW), .TMO_W(16), .TIMEOUT(16)) u_wdg (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .cont_mode(cont_mode),
    .frame_len(frame_len), .data_in_valid(data_in_valid), .data_in_ready(wd_data_in_ready),
    .sos_out_valid(sos_out_valid), .sos_out_data(sos_out_data), .pipeline_en(wd_pipeline_en),
    .addr(wd_addr), .data_out(wd_data_out), .data_out_valid(wd_data_out_valid),
    .data_out_ready(data_out_ready), .busy(wd_busy), .stable_out(wd_stable_out),
    .filter_done(wd_filter_done), .timeout_err(wd_timeout_err), .frame_cnt(wd_frame_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [AW-1:0] a;
  } exp_t;

  exp_t          exp_q[$];
  int            n_checks = 0;
  int            n_fail = 0;
  int            run_len, run_idx, done_cnt, out_cnt, in_acc, pe_zero_cnt;
  logic          run_cont;
  logic          hold_v = 1'b0;
  logic [DW-1:0] hold_d;
  logic [AW-1:0] hold_a;
  logic [AW-1:0] last_addr;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive at posedge+1, observe at posedge+2, return at next posedge+1.
  task automatic step(input logic v, input logic rdy);
    logic [DW-1:0] d;
    d = DW'($urandom);
    sos_out_valid  = v;
    sos_out_data   = d;
    data_out_ready = rdy;
    data_in_valid  = 1'b1;
    #1;
    if (hold_v) begin
      check_eq("hold_valid", data_out_valid, 1'b1);
      check_eq("hold_data", unsigned'(data_out), hold_d);
      check_eq("hold_addr", addr, hold_a);
    end
    hold_v = data_out_valid & ~rdy;
    hold_d = unsigned'(data_out);
    hold_a = addr;
    if (!pipeline_en) pe_zero_cnt++;
    check_eq("stall_gate", pipeline_en & data_out_valid & ~rdy, 1'b0);
    check_eq("in_ready_gate", data_in_ready & ~pipeline_en, 1'b0);
    if (filter_done) begin
      done_cnt++;
      check_eq("done_in_cnt", in_acc, done_cnt * run_len);
      check_eq("done_out_cnt", out_cnt, done_cnt * run_len);
      check_eq("done_frame_cnt", frame_cnt, done_cnt);
      check_eq("done_stable", stable_out, run_cont);
    end
    if (data_out_valid && rdy) begin
      out_cnt++;
      check_eq("out_pending", exp_q.size() != 0, 1'b1);
      if (exp_q.size() != 0) begin
        exp_t e;
        e = exp_q.pop_front();
        check_eq("out_data", unsigned'(data_out), e.d);
        check_eq("out_addr", addr, e.a);
      end
      last_addr = addr;
    end
    if (data_in_valid && data_in_ready) in_acc++;
    if (v && pipeline_en) begin
      exp_q.push_back({d, AW'(run_idx % run_len)});
      run_idx++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(input logic [AW:0] len, input logic cont);
    frame_len = len;
    cont_mode = cont;
    run_len   = ((len == 0) || (len > MAXLEN)) ? MAXLEN : int'(len);
    run_cont  = cont;
    run_idx   = 0;
    done_cnt  = 0;
    out_cnt   = 0;
    in_acc    = 0;
    exp_q.delete();
    start = 1'b1;
    step(1'b0, 1'b1);
    start = 1'b0;
    check_eq("start_busy", busy, 1'b1);
    check_eq("start_frame_cnt", frame_cnt, 16'd0);
  endtask

  task automatic run_until(input int target, input int budget, input int pv, input int pr);
    int n;
    n = 0;
    while (done_cnt < target && n < budget) begin
      step($urandom_range(99) < pv, $urandom_range(99) < pr);
      n++;
    end
    check_eq("frame_done_in_budget", done_cnt, target);
  endtask

  task automatic settle_idle(input int frames);
    repeat (4) step(1'b0, 1'b1);
    check_eq("idle_busy", busy, 1'b0);
    check_eq("idle_valid", data_out_valid, 1'b0);
    check_eq("idle_stable", stable_out, 1'b0);
    check_eq("idle_queue", exp_q.size(), 0);
    check_eq("idle_out_cnt", out_cnt, frames * run_len);
    check_eq("idle_frame_cnt", frame_cnt, frames);
  endtask

  task automatic do_abort();
    abort = 1'b1;
    step(1'b0, 1'b1);
    abort = 1'b0;
    hold_v = 1'b0;
    exp_q.delete();
    check_eq("abort_busy", busy, 1'b0);
    check_eq("abort_stable", stable_out, 1'b0);
    check_eq("abort_valid", data_out_valid, 1'b0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL global_time_limit: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cnt;
    logic [AW:0] rl;
    logic        rc;

    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_valid", data_out_valid, 1'b0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_pe", pipeline_en, 1'b0);
    check_eq("rst_in_ready", data_in_ready, 1'b0);
    check_eq("rst_done", filter_done, 1'b0);
    check_eq("rst_tmo", timeout_err, 1'b0);
    check_eq("rst_stable", stable_out, 1'b0);
    check_eq("rst_frame_cnt", frame_cnt, 16'd0);
    check_eq("rst_addr", addr, '0);
    check_eq("rst_data", unsigned'(data_out), '0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single frame, free-flowing.
    start_run(12'd8, 1'b0);
    run_until(1, 40, 100, 100);
    settle_idle(1);

    // Backpressure: sink blocks for three cycles after the second sample.
    start_run(12'd4, 1'b0);
    cnt = 0;
    pe_zero_cnt = 0;
    while (done_cnt < 1 && cnt < 60) begin
      if (out_cnt == 2 && cnt < 3) begin
        step(1'b1, 1'b0);
        cnt++;
      end else begin
        step(1'b1, 1'b1);
        if (out_cnt >= 2 && cnt < 3) cnt = cnt;
      end
    end
    check_eq("bp_low_cycles", cnt, 3);
    check_eq("bp_done", done_cnt, 1);
    settle_idle(1);

    // Continuous mode, three frames, then abort keeps frame_cnt.
    start_run(12'd5, 1'b1);
    run_until(3, 200, 100, 100);
    check_eq("cont_stable", stable_out, 1'b1);
    check_eq("cont_busy", busy, 1'b1);
    do_abort();
    check_eq("cont_abort_frame_cnt", frame_cnt, 16'd3);

    // Random lengths and handshake densities.
    for (int i = 0; i < 8; i++) begin
      rl = 12'($urandom_range(12, 1));
      rc = 1'($urandom_range(1));
      start_run(rl, rc);
      run_until(rc ? 2 : 1, 600, $urandom_range(90, 30), $urandom_range(90, 30));
      if (rc) begin
        do_abort();
        check_eq("rand_abort_frame_cnt", frame_cnt, 16'd2);
      end else begin
        settle_idle(1);
      end
    end

    // Zero and oversize lengths both mean the maximum frame.
    start_run(12'd0, 1'b0);
    run_until(1, 2200, 100, 100);
    check_eq("len0_last_addr", last_addr, 11'd2047);
    settle_idle(1);
    start_run(12'hFFF, 1'b0);
    run_until(1, 3000, 100, 80);
    check_eq("lenmax_last_addr", last_addr, 11'd2047);
    settle_idle(1);

    // Watchdog on the short-timeout instance.
    start_run(12'd8, 1'b0);
    cnt = 0;
    while (!wd_timeout_err && cnt < 40) begin
      step(1'b0, 1'b1);
      cnt++;
    end
    check_eq("wdg_cycles", cnt, 16);
    check_eq("wdg_pe", wd_pipeline_en, 1'b0);
    check_eq("wdg_busy", wd_busy, 1'b1);
    check_eq("main_no_tmo", timeout_err, 1'b0);
    start = 1'b1;
    step(1'b0, 1'b1);
    start = 1'b0;
    check_eq("wdg_restart_tmo", wd_timeout_err, 1'b0);
    check_eq("wdg_restart_busy", wd_busy, 1'b1);
    do_abort();
    check_eq("wdg_abort_busy", wd_busy, 1'b0);

    // Abort after three outputs of eight.
    start_run(12'd8, 1'b0);
    cnt = 0;
    while (out_cnt < 3 && cnt < 30) begin
      step(1'b1, 1'b1);
      cnt++;
    end
    check_eq("abort_at3", out_cnt, 3);
    do_abort();
    repeat (6) step(1'b1, 1'b1);
    check_eq("abort_no_done", done_cnt, 0);
    check_eq("abort_idle", busy, 1'b0);

    // Asynchronous reset mid-frame, with the short-timeout instance in error.
    start_run(12'd8, 1'b0);
    repeat (20) step(1'b0, 1'b1);
    repeat (3) step(1'b1, 1'b1);
    check_eq("pre_rst_wdg_tmo", wd_timeout_err, 1'b1);
    check_eq("pre_rst_valid", data_out_valid, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_valid", data_out_valid, 1'b0);
    check_eq("arst_busy", busy, 1'b0);
    check_eq("arst_stable", stable_out, 1'b0);
    check_eq("arst_pe", pipeline_en, 1'b0);
    check_eq("arst_in_ready", data_in_ready, 1'b0);
    check_eq("arst_data", unsigned'(data_out), '0);
    check_eq("arst_addr", addr, '0);
    check_eq("arst_wdg_tmo", wd_timeout_err, 1'b0);
    hold_v = 1'b0;
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
